// File: rtl/fb_pixel_writer.sv
// Frame buffer write side: buffers RTU pixels in a small FIFO and drains them
// one per cycle in raster order to the frame buffer port, addr = {x, y}.
module fb_pixel_writer #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int COORD_W    = 9,
  parameter int COLOR_W    = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [COLOR_W-1:0]     in_data,
  output logic                   in_ready,
  output logic [2*COORD_W-1:0]   fb_addr,
  output logic [COLOR_W-1:0]     fb_data,
  output logic                   fb_we,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  localparam logic [CNT_W-1:0]   TOTAL_C = CNT_W'(TOTAL);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_RES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITING = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [COLOR_W-1:0]   mem_r [FIFO_DEPTH];
  logic [CNT_W-1:0]     accept_cnt_r;
  logic [COORD_W-1:0]   x_r;
  logic [COORD_W-1:0]   y_r;

  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 last_s;
  logic                 frame_start_s;

  // FIFO status, handshake and drain decisions; in_ready depends only on registers
  always_comb begin
    fifo_empty_s  = (wr_ptr_r == rd_ptr_r);
    fifo_full_s   = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    in_ready      = (state_r == WRITING) && !fifo_full_s && (accept_cnt_r < TOTAL_C);
    push_s        = in_valid && in_ready;
    pop_s         = (state_r == WRITING) && !fifo_empty_s;
    last_s        = pop_s && (x_r == X_LAST) && (y_r == Y_LAST);
    frame_start_s = (state_r == IDLE) && start;
  end

  // Next-state logic: start only matters in IDLE, last pop ends the frame
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = WRITING;
        end else begin
          state_s = IDLE;
        end
      end
      WRITING: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = WRITING;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FIFO storage and pointers; the extra pointer bit separates full from empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {COLOR_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= in_data;
        wr_ptr_r                <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Accept counter and raster position; cleared when a frame starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accept_cnt_r <= {CNT_W{1'b0}};
      x_r          <= {COORD_W{1'b0}};
      y_r          <= {COORD_W{1'b0}};
    end else if (frame_start_s) begin
      accept_cnt_r <= {CNT_W{1'b0}};
      x_r          <= {COORD_W{1'b0}};
      y_r          <= {COORD_W{1'b0}};
    end else begin
      if (push_s) begin
        accept_cnt_r <= accept_cnt_r + CNT_W'(1);
      end
      if (pop_s) begin
        if (x_r == X_LAST) begin
          x_r <= {COORD_W{1'b0}};
          if (y_r == Y_LAST) begin
            y_r <= {COORD_W{1'b0}};
          end else begin
            y_r <= y_r + COORD_W'(1);
          end
        end else begin
          x_r <= x_r + COORD_W'(1);
        end
      end
    end
  end

  // Registered frame buffer write port and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_we      <= 1'b0;
      fb_data    <= {COLOR_W{1'b0}};
      fb_addr    <= {(2*COORD_W){1'b0}};
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fb_we      <= pop_s;
      busy       <= (state_s == WRITING);
      frame_done <= (state_s == DONE);
      if (pop_s) begin
        fb_data <= mem_r[rd_ptr_r[AW-1:0]];
        fb_addr <= {x_r, y_r};
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer using a reduced frame size.
module tb_fb_pixel_writer;

  localparam int H     = 20;
  localparam int V     = 6;
  localparam int CW    = 9;
  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int TOTAL = H * V;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic [2*CW-1:0]   fb_addr;
  logic [DW-1:0]     fb_data;
  logic              fb_we;
  logic              busy;
  logic              frame_done;

  typedef struct {
    logic [2*CW-1:0] addr;
    logic [DW-1:0]   data;
    int              acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n = 0;
  int   base = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  bit   started = 1'b0;

  fb_pixel_writer #(
    .H_RES(H), .V_RES(V), .COORD_W(CW), .COLOR_W(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_we(fb_we), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Edge counter used to check write latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Output monitor: pops the scoreboard on every frame buffer write
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (fb_we) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          check("spurious_we", 32'(fb_addr), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("fb_addr", 32'(fb_addr), 32'(e.addr));
          check("fb_data", 32'(fb_data), 32'(e.data));
          check("latency", 32'(cyc), 32'(e.acc + 1));
        end
      end
      if (frame_done) begin
        done_cnt++;
        check("done_after_last", 32'(wr_cnt), 32'(TOTAL));
      end
    end
  end

  // One stimulus cycle; records accepted pixels with their expected address
  task automatic drive_px(input bit v, input bit st);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    start    = st;
    in_data  = DW'(n + base);
    #1;
    check("in_ready", 32'(in_ready), 32'(started && (n < TOTAL)));
    if (v && in_ready) begin
      e.addr = {CW'(n % H), CW'(n / H)};
      e.data = in_data;
      e.acc  = cyc + 1;
      sb.push_back(e);
      n++;
    end
  endtask

  task automatic do_start(input int b);
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    started  = 1'b1;
    n        = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    base     = b;
  endtask

  // mode 0: continuous, 1: bursts of 4 then 10 idle, 2: random 50%
  task automatic run_frame(input int mode);
    int  i = 0;
    bit  v;
    while (n < TOTAL && i < TOTAL * 4 + 50) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ((i % 14) < 4);
        default: v = 1'($urandom_range(1, 0));
      endcase
      drive_px(v, (mode == 1) && (i == TOTAL / 2));
      i++;
    end
    check("frame_fed", 32'(n), 32'(TOTAL));
  endtask

  task automatic finish_frame();
    int k = 0;
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    while (done_cnt == 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("frame_done_seen", 32'(done_cnt), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("done_single", 32'(done_cnt), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("we_after", 32'(fb_we), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("write_count", 32'(wr_cnt), 32'(TOTAL));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = {DW{1'b0}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // no start: nothing is accepted or written
    repeat (20) begin
      drive_px(1'b1, 1'b0);
      check("idle_we", 32'(fb_we), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // continuous stream
    do_start(0);
    check("busy_writing", 32'(busy), 32'd1);
    run_frame(0);
    finish_frame();

    // bursty stream, with an ignored start mid-frame
    do_start(12'h400);
    run_frame(1);
    finish_frame();

    // frame complete: further pixels refused
    repeat (10) begin
      drive_px(1'b1, 1'b0);
      check("post_frame_we", 32'(fb_we), 32'd0);
    end

    // random valid, second start restarts at (0,0)
    do_start(12'h800);
    check("busy_writing2", 32'(busy), 32'd1);
    run_frame(2);
    finish_frame();

    // reset mid-frame
    do_start(12'hC00);
    while (n < TOTAL / 2) drive_px(1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_we", 32'(fb_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    sb.delete();
    n        = 0;
    started  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      drive_px(1'b1, 1'b0);
      check("post_rst_we", 32'(fb_we), 32'd0);
    end
    do_start(12'h155);
    run_frame(0);
    finish_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
